// File: rtl/mux_pkg.sv
// Shared types and helpers for the N-way selector with skid buffering.
// Holds the buffer occupancy encoding and the select-width helper.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  // A two-way mux still needs a one-bit select, so never return zero.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer. Both out_valid and in_ready are registered,
// so neither depends combinationally on the opposite side of the handshake.
module skid_buf2
  import mux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic             push_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic             pop_ready
);

  state_e           state_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             valid_q;
  logic             ready_q;
  logic             push;
  logic             pop;

  assign push = push_valid & ready_q;
  assign pop  = valid_q & pop_ready;

  // ready_q stays low for the reset cycle itself and rises on the first
  // edge after rst drops; the state encoding alone would say "ready".
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          ready_q <= 1'b1;
          if (push) begin
            head_q  <= push_data;
            valid_q <= 1'b1;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_q <= push_data;
          end else if (pop) begin
            valid_q <= 1'b0;
            state_q <= EMPTY;
          end else if (push) begin
            skid_q  <= push_data;
            ready_q <= 1'b0;
            state_q <= TWO;
          end
        end
        TWO: begin
          if (pop) begin
            head_q  <= skid_q;
            ready_q <= 1'b1;
            state_q <= ONE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= EMPTY;
        end
      endcase
    end
  end

  assign push_ready = ready_q;
  assign pop_data   = head_q;
  assign pop_valid  = valid_q;

endmodule

// File: rtl/mux_n_skid.sv
// N-way registered selector feeding a two-entry skid buffer. Out-of-range
// selects are consumed, dropped and reported through pulse/sticky/counter.
module mux_n_skid
  import mux_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = clog2_min1(NUM_IN),
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    err,
  output logic                    err_sticky,
  output logic [CNT_W-1:0]        err_count,
  input  logic                    err_clear
);

  logic             sel_legal;
  logic [WIDTH-1:0] sel_data;
  logic             buf_ready;
  logic             bad_fire;
  logic             err_q;
  logic             sticky_q;
  logic             sticky_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_base;

  // With a power-of-two input count every select code is valid.
  if (NUM_IN == (1 << SEL_W)) begin : g_full_range
    assign sel_legal = 1'b1;
  end else begin : g_partial_range
    localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);
    assign sel_legal = ({1'b0, sel} < NUM_IN_EXT);
  end

  // AND-OR mux: an out-of-range select matches no input and yields zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = sel_data | in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  skid_buf2 #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push_data (sel_data),
    .push_valid(in_valid & sel_legal),
    .push_ready(buf_ready),
    .pop_data  (out_data),
    .pop_valid (out_valid),
    .pop_ready (out_ready)
  );

  assign in_ready = buf_ready;
  assign bad_fire = in_valid & buf_ready & ~sel_legal;

  // Clear is applied before the new error is counted in the same cycle.
  always_comb begin
    cnt_base = err_clear ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (bad_fire && (cnt_base != {CNT_W{1'b1}})) begin
      cnt_d = cnt_base + CNT_W'(1);
    end
    sticky_d = bad_fire | (sticky_q & ~err_clear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      err_q    <= bad_fire;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_count  = cnt_q;

endmodule

// File: tb/tb_mux_n_skid.sv
// Self-checking bench for mux_n_skid: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_mux_n_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Main instance: WIDTH=16, NUM_IN=3, CNT_W=8
  logic        rst_a;
  logic [47:0] a_data;
  logic [1:0]  a_sel;
  logic        a_vld, a_ir, a_ov, a_ordy, a_err, a_sticky, a_clr;
  logic [15:0] a_od;
  logic [7:0]  a_cnt;

  mux_n_skid #(.WIDTH(16), .NUM_IN(3), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .in_data(a_data), .sel(a_sel), .in_valid(a_vld),
    .in_ready(a_ir), .out_data(a_od), .out_valid(a_ov), .out_ready(a_ordy),
    .err(a_err), .err_sticky(a_sticky), .err_count(a_cnt), .err_clear(a_clr));

  // Narrow-counter instance: CNT_W=2
  logic        rst_c;
  logic [47:0] c_data;
  logic [1:0]  c_sel;
  logic        c_vld, c_ir, c_ov, c_ordy, c_err, c_sticky, c_clr;
  logic [15:0] c_od;
  logic [1:0]  c_cnt;

  mux_n_skid #(.WIDTH(16), .NUM_IN(3), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst_c), .in_data(c_data), .sel(c_sel), .in_valid(c_vld),
    .in_ready(c_ir), .out_data(c_od), .out_valid(c_ov), .out_ready(c_ordy),
    .err(c_err), .err_sticky(c_sticky), .err_count(c_cnt), .err_clear(c_clr));

  // Sweep instances: WIDTH=8, NUM_IN=4 and NUM_IN=5
  logic        rst_s;
  logic [31:0] s4_data;
  logic [1:0]  s4_sel;
  logic        s4_vld, s4_ir, s4_ov, s4_ordy, s4_err, s4_sticky;
  logic [7:0]  s4_od, s4_cnt;
  logic [39:0] s5_data;
  logic [2:0]  s5_sel;
  logic        s5_vld, s5_ir, s5_ov, s5_ordy, s5_err, s5_sticky;
  logic [7:0]  s5_od, s5_cnt;

  mux_n_skid #(.WIDTH(8), .NUM_IN(4), .CNT_W(8)) dut_4 (
    .clk(clk), .rst(rst_s), .in_data(s4_data), .sel(s4_sel), .in_valid(s4_vld),
    .in_ready(s4_ir), .out_data(s4_od), .out_valid(s4_ov), .out_ready(s4_ordy),
    .err(s4_err), .err_sticky(s4_sticky), .err_count(s4_cnt), .err_clear(1'b0));

  mux_n_skid #(.WIDTH(8), .NUM_IN(5), .CNT_W(8)) dut_5 (
    .clk(clk), .rst(rst_s), .in_data(s5_data), .sel(s5_sel), .in_valid(s5_vld),
    .in_ready(s5_ir), .out_data(s5_od), .out_valid(s5_ov), .out_ready(s5_ordy),
    .err(s5_err), .err_sticky(s5_sticky), .err_count(s5_cnt), .err_clear(1'b0));

  // Reference model for dut_a: buffer contents as a FIFO of accepted beats.
  logic [15:0] mq[$];
  logic [15:0] m_head;
  bit          m_rdy, m_err, m_sticky;
  int          m_cnt;

  function automatic logic [27:0] exp_a();
    return {(mq.size() > 0), m_head, m_rdy, m_err, m_sticky, 8'(m_cnt)};
  endfunction

  function automatic logic [27:0] obs_a();
    return {a_ov, a_od, a_ir, a_err, a_sticky, a_cnt};
  endfunction

  // Drive one clock of stimulus on dut_a and advance the model; returns at negedge.
  task automatic cycle_a(input bit v, input int s, input bit ordy, input bit clr, input bit r);
    bit fire, legal;
    logic [15:0] d;
    d = '0;
    a_vld = v; a_sel = 2'(s); a_ordy = ordy; a_clr = clr; rst_a = r;
    if (s < 3) d = a_data[s*16 +: 16];
    @(posedge clk);
    if (r) begin
      mq.delete(); m_head = '0; m_rdy = 0; m_err = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      fire  = v && m_rdy;
      legal = (s < 3);
      if (ordy && mq.size() > 0) void'(mq.pop_front());
      if (fire && legal) mq.push_back(d);
      if (mq.size() > 0) m_head = mq[0];
      if (clr) begin m_sticky = 0; m_cnt = 0; end
      m_err = fire && !legal;
      if (m_err) begin
        m_sticky = 1;
        if (m_cnt < 255) m_cnt++;
      end
      m_rdy = (mq.size() < 2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_c = 1; rst_s = 1;
    cycle_a(0, 0, 0, 0, 1);
    cycle_a(1, 1, 1, 0, 1);
    if ({a_ov, a_ir, a_err, a_sticky, a_cnt, a_od} !== 28'h0) begin
      errors++; $display("FAIL reset_a got=%h exp=0", {a_ov, a_ir, a_err, a_sticky, a_cnt, a_od});
    end
    checks++;
    if ({c_ov, c_ir, c_err, c_sticky, c_cnt} !== 6'h0) begin
      errors++; $display("FAIL reset_c got=%h exp=0", {c_ov, c_ir, c_err, c_sticky, c_cnt});
    end
    checks++;
    rst_c = 0; rst_s = 0;
    cycle_a(0, 0, 0, 0, 0);
    if ({a_ir, c_ir, s4_ir, s5_ir, a_ov} !== 5'b11110) begin
      errors++; $display("FAIL reset_release got=%b exp=11110", {a_ir, c_ir, s4_ir, s5_ir, a_ov});
    end
    checks++;
  endtask

  task automatic test_stream();
    logic [15:0] want[3];
    want[0] = 16'h1111; want[1] = 16'h2222; want[2] = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      cycle_a(1, i, 1, 0, 0);
      if ({a_ov, a_ir, a_od} !== {2'b11, want[i]}) begin
        errors++; $display("FAIL stream_beat%0d got=%h exp=%h", i, {a_ov, a_ir, a_od}, {2'b11, want[i]});
      end
      checks++;
      if (obs_a() !== exp_a()) begin
        errors++; $display("FAIL stream_model%0d got=%h exp=%h", i, obs_a(), exp_a());
      end
      checks++;
    end
    cycle_a(0, 0, 1, 0, 0);
    if (obs_a() !== exp_a() || a_ov !== 1'b0) begin
      errors++; $display("FAIL stream_drain got=%h exp=%h", obs_a(), exp_a());
    end
    checks++;
  endtask

  task automatic test_backpressure();
    cycle_a(1, 1, 0, 0, 0);
    cycle_a(1, 2, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      if ({a_ov, a_ir, a_od} !== {2'b10, 16'h2222}) begin
        errors++; $display("FAIL bp_full%0d got=%h exp=%h", i, {a_ov, a_ir, a_od}, {2'b10, 16'h2222});
      end
      checks++;
      cycle_a(1, 0, 0, 0, 0);
    end
    cycle_a(0, 0, 1, 0, 0);
    if ({a_ov, a_ir, a_od} !== {2'b11, 16'h3333}) begin
      errors++; $display("FAIL bp_pop1 got=%h exp=%h", {a_ov, a_ir, a_od}, {2'b11, 16'h3333});
    end
    checks++;
    cycle_a(0, 0, 1, 0, 0);
    if (obs_a() !== exp_a() || a_ov !== 1'b0) begin
      errors++; $display("FAIL bp_pop2 got=%h exp=%h", obs_a(), exp_a());
    end
    checks++;
  endtask

  task automatic test_illegal();
    cycle_a(1, 0, 0, 0, 0);
    cycle_a(1, 3, 0, 0, 0);
    if ({a_err, a_sticky, a_cnt, a_ov, a_ir, a_od} !== {2'b11, 8'd1, 2'b11, 16'h1111}) begin
      errors++; $display("FAIL illegal_event got=%h exp=%h", {a_err, a_sticky, a_cnt, a_ov, a_ir, a_od},
                         {2'b11, 8'd1, 2'b11, 16'h1111});
    end
    checks++;
    cycle_a(0, 0, 0, 0, 0);
    if ({a_err, a_sticky, a_cnt, a_ov, a_od} !== {2'b01, 8'd1, 1'b1, 16'h1111}) begin
      errors++; $display("FAIL illegal_after got=%h exp=%h", {a_err, a_sticky, a_cnt, a_ov, a_od},
                         {2'b01, 8'd1, 1'b1, 16'h1111});
    end
    checks++;
    cycle_a(0, 0, 1, 0, 0);
    if (obs_a() !== exp_a()) begin
      errors++; $display("FAIL illegal_drain got=%h exp=%h", obs_a(), exp_a());
    end
    checks++;
  endtask

  task automatic test_saturate_clear();
    int want;
    for (int i = 0; i < 5; i++) begin
      c_vld = 1; c_sel = 2'd3; c_clr = 0;
      @(posedge clk); @(negedge clk);
      want = (i + 1 > 3) ? 3 : i + 1;
      if ({c_err, c_sticky, c_cnt, c_ov} !== {2'b11, 2'(want), 1'b0}) begin
        errors++; $display("FAIL sat_%0d got=%b exp=%b", i, {c_err, c_sticky, c_cnt, c_ov}, {2'b11, 2'(want), 1'b0});
      end
      checks++;
    end
    c_vld = 0; c_clr = 1;
    @(posedge clk); @(negedge clk);
    if ({c_err, c_sticky, c_cnt} !== 4'b0000) begin
      errors++; $display("FAIL clear_alone got=%b exp=0000", {c_err, c_sticky, c_cnt});
    end
    checks++;
    c_vld = 1; c_sel = 2'd3; c_clr = 1;
    @(posedge clk); @(negedge clk);
    if ({c_err, c_sticky, c_cnt} !== 4'b1101) begin
      errors++; $display("FAIL clear_with_err got=%b exp=1101", {c_err, c_sticky, c_cnt});
    end
    checks++;
    c_vld = 0; c_clr = 0;
  endtask

  task automatic test_reset_mid();
    cycle_a(1, 0, 0, 0, 0);
    cycle_a(1, 1, 0, 0, 0);
    if ({a_ov, a_ir, a_sticky} !== 3'b101) begin
      errors++; $display("FAIL rmid_pre got=%b exp=101", {a_ov, a_ir, a_sticky});
    end
    checks++;
    cycle_a(1, 2, 1, 0, 1);
    if ({a_ov, a_ir, a_err, a_sticky, a_cnt, a_od} !== 28'h0) begin
      errors++; $display("FAIL rmid_in_reset got=%h exp=0", {a_ov, a_ir, a_err, a_sticky, a_cnt, a_od});
    end
    checks++;
    for (int i = 0; i < 3; i++) begin
      cycle_a(0, 0, 1, 0, 0);
      if ({a_ov, a_ir} !== 2'b01 || obs_a() !== exp_a()) begin
        errors++; $display("FAIL rmid_after%0d got=%h exp=%h", i, obs_a(), exp_a());
      end
      checks++;
    end
  endtask

  task automatic test_random_a();
    for (int i = 0; i < 300; i++) begin
      a_data = {$urandom, $urandom};
      cycle_a(($urandom % 4) != 0, int'($urandom % 4), ($urandom % 3) != 0, ($urandom % 16) == 0, 0);
      if (obs_a() !== exp_a()) begin
        errors++; $display("FAIL random_a cyc%0d got=%h exp=%h", i, obs_a(), exp_a());
      end
      checks++;
    end
  endtask

  task automatic test_sweep();
    logic [7:0] q4[$], q5[$];
    logic [7:0] h4, h5, d4, d5;
    bit r4, r5, e4, e5, f;
    int ill4, ill5, pulses5, s;
    h4 = '0; h5 = '0; r4 = 1; r5 = 1; e4 = 0; e5 = 0;
    ill4 = 0; ill5 = 0; pulses5 = 0;
    for (int i = 0; i < 800; i++) begin
      if ({s4_ov, s4_od, s4_ir, s4_err} !== {(q4.size() > 0), h4, r4, e4}) begin
        errors++; $display("FAIL sweep4 cyc%0d got=%h exp=%h", i, {s4_ov, s4_od, s4_ir, s4_err}, {(q4.size() > 0), h4, r4, e4});
      end
      checks++;
      if ({s5_ov, s5_od, s5_ir, s5_err} !== {(q5.size() > 0), h5, r5, e5}) begin
        errors++; $display("FAIL sweep5 cyc%0d got=%h exp=%h", i, {s5_ov, s5_od, s5_ir, s5_err}, {(q5.size() > 0), h5, r5, e5});
      end
      checks++;
      pulses5 += int'(s5_err);
      s4_data = $urandom; s4_sel = 2'($urandom); s4_vld = ($urandom % 4) != 0; s4_ordy = $urandom % 2;
      s5_data = {$urandom, $urandom}; s5_sel = 3'($urandom); s5_vld = ($urandom % 4) != 0; s5_ordy = $urandom % 2;
      s = int'(s4_sel);
      d4 = s4_data[s*8 +: 8];
      s = int'(s5_sel);
      d5 = (s < 5) ? s5_data[s*8 +: 8] : 8'h0;
      @(posedge clk);
      f = s4_vld && r4;
      if (s4_ordy && q4.size() > 0) void'(q4.pop_front());
      if (f) q4.push_back(d4);
      if (q4.size() > 0) h4 = q4[0];
      r4 = (q4.size() < 2);
      f = s5_vld && r5;
      if (s5_ordy && q5.size() > 0) void'(q5.pop_front());
      if (f && s < 5) q5.push_back(d5);
      e5 = f && (s >= 5);
      if (e5) ill5++;
      if (q5.size() > 0) h5 = q5[0];
      r5 = (q5.size() < 2);
      @(negedge clk);
    end
    pulses5 += int'(s5_err);
    s4_vld = 0; s5_vld = 0;
    if ({s4_cnt, s4_sticky} !== {8'(ill4), 1'b0}) begin
      errors++; $display("FAIL sweep4_errs got=%0d exp=%0d", s4_cnt, ill4);
    end
    checks++;
    if ({s5_cnt, s5_sticky} !== {8'((ill5 > 255) ? 255 : ill5), (ill5 > 0)}) begin
      errors++; $display("FAIL sweep5_errs got=%0d exp=%0d", s5_cnt, ill5);
    end
    checks++;
    if (pulses5 !== ill5) begin
      errors++; $display("FAIL sweep5_pulses got=%0d exp=%0d", pulses5, ill5);
    end
    checks++;
  endtask

  initial begin
    a_data = {16'h3333, 16'h2222, 16'h1111};
    a_sel = '0; a_vld = 0; a_ordy = 0; a_clr = 0; rst_a = 1;
    c_data = {16'h3333, 16'h2222, 16'h1111};
    c_sel = '0; c_vld = 0; c_ordy = 1; c_clr = 0; rst_c = 1;
    s4_data = '0; s4_sel = '0; s4_vld = 0; s4_ordy = 0;
    s5_data = '0; s5_sel = '0; s5_vld = 0; s5_ordy = 0; rst_s = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_illegal();
    test_saturate_clear();
    test_reset_mid();
    test_random_a();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
